// File: rtl/event_tx_queue_pkg.sv
// Shared types and word packers for the event transmit queue.
// Event words carry the motif in [63:60]; markers carry tag F in [59:56] and the frame index.
package event_tx_queue_pkg;

  localparam logic [3:0] MARKER_TAG = 4'hF;
  localparam int         EVT_W      = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } drain_state_t;

  // Masking keeps the low 56 delta bits; the motif replaces the top byte.
  function automatic logic [EVT_W-1:0] pack_event(input logic [3:0]  motif,
                                                  input logic [63:0] delta);
    return {motif, 4'h0, 56'h0} | (delta & 64'h00FF_FFFF_FFFF_FFFF);
  endfunction

  function automatic logic [EVT_W-1:0] pack_marker(input logic [15:0] idx);
    return {4'h0, MARKER_TAG, 40'h0, idx};
  endfunction

endpackage

// File: rtl/event_tx_queue_if.sv
// Event input and uart_tx_64 start/busy/done handshake, grouped for the queue.
// The slave side is the queue; the master side is classifier plus UART.
interface event_tx_queue_if;

  logic        ev_valid;
  logic [3:0]  ev_motif;
  logic [63:0] ev_delta;
  logic        frame_sync;
  logic [63:0] tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output ev_valid, ev_motif, ev_delta, frame_sync, tx_busy, tx_done,
    input  tx_data, tx_start
  );

  modport slave (
    input  ev_valid, ev_motif, ev_delta, frame_sync, tx_busy, tx_done,
    output tx_data, tx_start
  );

endinterface

// File: rtl/event_tx_queue_sync_fifo.sv
// Synchronous FIFO with AW+1 bit wrapping pointers; head is read combinationally.
// A push while full is accepted only if a pop happens in the same cycle.
module event_tx_queue_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/event_tx_queue.sv
// Queues packed events and frame markers, draining one word per UART start/done cycle.
// Event accepted into an idle empty queue gives tx_start two cycles later; events arriving while full are dropped and counted.
module event_tx_queue
  import event_tx_queue_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  event_tx_queue_if.slave   bus,
  output logic [AW:0]       fifo_count,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam logic [DROP_W-1:0] DROP_ONE = 1;

  drain_state_t     state;
  logic [15:0]      frame_idx;
  logic             marker_pend;
  logic [EVT_W-1:0] tx_data_q;
  logic             tx_start_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             fifo_push;
  logic             marker_wr;
  logic             ev_drop;
  logic [EVT_W-1:0] push_dat;
  logic [EVT_W-1:0] head_dat;

  // Events own the write port; a pending marker takes the first idle cycle with room.
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !bus.tx_busy;
  assign marker_wr = marker_pend && !bus.ev_valid && (!fifo_full || fifo_pop);
  assign fifo_push = bus.ev_valid || marker_wr;
  assign push_dat  = bus.ev_valid ? pack_event(bus.ev_motif, bus.ev_delta)
                                  : pack_marker(frame_idx);
  assign ev_drop   = bus.ev_valid && fifo_full && !fifo_pop;

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

  event_tx_queue_sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_idx   <= '0;
      marker_pend <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
    end else begin
      // A new frame re-arms the marker even if the old one is written this cycle.
      if (bus.frame_sync) begin
        frame_idx   <= frame_idx + 16'd1;
        marker_pend <= 1'b1;
      end else if (marker_wr) begin
        marker_pend <= 1'b0;
      end
      if (ev_drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROP_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx_start_q <= 1'b0;
          if (fifo_pop) begin
            tx_data_q  <= head_dat;
            tx_start_q <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          tx_start_q <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          tx_start_q <= 1'b0;
          if (bus.tx_done) state <= ST_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_tx_queue.sv
// Directed bench for event_tx_queue: expected words go into a scoreboard queue,
// a negedge monitor compares each word the DUT starts; a second tiny instance covers drop saturation.
module tb_event_tx_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic hold_busy = 1'b0;
  logic uart_busy = 1'b0;
  logic uart_en   = 1'b0;
  logic tx_done_r = 1'b0;

  event_tx_queue_if bus ();
  event_tx_queue_if bus_s ();

  assign bus.tx_busy = hold_busy | uart_busy;
  assign bus.tx_done = tx_done_r;

  assign bus_s.tx_busy    = 1'b1;
  assign bus_s.tx_done    = 1'b0;
  assign bus_s.frame_sync = 1'b0;
  assign bus_s.ev_motif   = 4'h5;

  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;
  logic [1:0]  cnt_s;
  logic        ovf_s;
  logic [1:0]  drop_s;

  event_tx_queue #(.DEPTH(16), .AW(4), .DROP_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  event_tx_queue #(.DEPTH(2), .AW(1), .DROP_W(2)) dut_s (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_s),
    .fifo_count (cnt_s),
    .overflow   (ovf_s),
    .drop_count (drop_s)
  );

  int          tests     = 0;
  int          fails     = 0;
  int          start_cnt = 0;
  logic        prev_start = 1'b0;
  logic [63:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_event(input logic [3:0] m, input logic [63:0] d);
    return {m, 4'h0, d[55:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ev(input logic [3:0] m, input logic [63:0] d, input bit accept);
    bus.ev_valid = 1'b1;
    bus.ev_motif = m;
    bus.ev_delta = d;
    if (accept) exp_q.push_back(model_event(m, d));
    tick();
    bus.ev_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (12) tick();
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every start must carry the oldest expected word and last one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        start_cnt++;
        check("start_one_cycle", {63'd0, prev_start}, 64'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx_start: got word 0x%0h, expected no start", bus.tx_data);
        end else begin
          check("tx_data_order", bus.tx_data, exp_q.pop_front());
        end
      end
      prev_start = bus.tx_start;
    end
  end

  // UART model: busy for a few cycles after each start, then a one-cycle done.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (uart_en && bus.tx_start === 1'b1) begin
        uart_busy = 1'b1;
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        tx_done_r = 1'b1;
        uart_busy = 1'b0;
        @(posedge clk);
        #1;
        tx_done_r = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst            = 1'b1;
    bus.ev_valid   = 1'b0;
    bus.ev_motif   = 4'h0;
    bus.ev_delta   = 64'h0;
    bus.frame_sync = 1'b0;
    bus_s.ev_valid = 1'b0;
    bus_s.ev_delta = 64'h0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_tx_start",   64'(bus.tx_start), 64'd0);
    check("rst_tx_data",    bus.tx_data, 64'd0);
    check("rst_overflow",   64'(overflow), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    tick();
    rst     = 1'b0;
    uart_en = 1'b1;
    tick();

    // 1: single event, latency and packing
    exp_q.push_back(64'h30AB_0000_0000_1234);
    send_ev(4'd3, 64'h00AB_0000_0000_1234, 1'b0);
    @(negedge clk);
    check("latency_not_early", 64'(bus.tx_start), 64'd0);
    @(negedge clk);
    check("latency_start", 64'(bus.tx_start), 64'd1);
    wait_drain();

    // 2: burst of 20 while busy; top byte of delta must be discarded
    hold_busy = 1'b1;
    for (int i = 0; i < 20; i++)
      send_ev(4'(i), 64'hA500_0000_0000_0000 | 64'(i), i < 16);
    @(negedge clk);
    check("burst_fifo_count", 64'(fifo_count), 64'd16);
    check("burst_drop_count", 64'(drop_count), 64'd4);
    check("burst_overflow",   64'(overflow), 64'd1);
    tick();
    hold_busy = 1'b0;
    wait_drain();
    check("burst_drained_count", 64'(fifo_count), 64'd0);

    // 3: marker, then two frame_syncs while full collapse into one marker
    exp_q.push_back(64'h0F00_0000_0000_0001);
    pulse_sync();
    wait_drain();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++)
      send_ev(4'hC, 64'h0000_0000_0000_0100 + 64'(i), 1'b1);
    pulse_sync();
    pulse_sync();
    exp_q.push_back(64'h0F00_0000_0000_0003);
    @(negedge clk);
    check("full_marker_count", 64'(fifo_count), 64'd16);
    check("marker_not_drop",   64'(drop_count), 64'd4);
    tick();
    hold_busy = 1'b0;
    wait_drain();

    // 4: event and frame_sync together -> event first, then marker 4
    bus.frame_sync = 1'b1;
    send_ev(4'h7, 64'h0000_1111_2222_3333, 1'b1);
    bus.frame_sync = 1'b0;
    exp_q.push_back(64'h0F00_0000_0000_0004);
    wait_drain();

    // 5: push and pop in the same cycle while full
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++)
      send_ev(4'h2, 64'h0000_0000_0000_0200 + 64'(i), 1'b1);
    @(negedge clk);
    check("pre_pushpop_count", 64'(fifo_count), 64'd16);
    tick();
    hold_busy = 1'b0;
    send_ev(4'hE, 64'h0000_0000_DEAD_BEEF, 1'b1);
    @(negedge clk);
    check("pushpop_count", 64'(fifo_count), 64'd16);
    check("pushpop_drops", 64'(drop_count), 64'd4);
    wait_drain();

    // 5b: drop counter saturation on the small instance (DEPTH=2, DROP_W=2)
    for (int i = 0; i < 4; i++) begin
      bus_s.ev_valid = 1'b1;
      bus_s.ev_delta = 64'(i);
      tick();
    end
    bus_s.ev_valid = 1'b0;
    @(negedge clk);
    check("small_count", 64'(cnt_s), 64'd2);
    check("small_drop_2", 64'(drop_s), 64'd2);
    check("small_overflow", 64'(ovf_s), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus_s.ev_valid = 1'b1;
      tick();
    end
    bus_s.ev_valid = 1'b0;
    @(negedge clk);
    check("small_drop_sat", 64'(drop_s), 64'd3);

    // 6: reset while waiting on the UART with 5 entries queued
    tick();
    uart_en = 1'b0;
    for (int i = 0; i < 6; i++)
      send_ev(4'h1, 64'h0000_0000_0000_0600 + 64'(i), 1'b1);
    repeat (2) tick();
    @(negedge clk);
    check("pre_rst_count", 64'(fifo_count), 64'd5);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_count",    64'(fifo_count), 64'd0);
    check("post_rst_tx_start", 64'(bus.tx_start), 64'd0);
    check("post_rst_drops",    64'(drop_count), 64'd0);
    check("post_rst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    s0  = start_cnt;
    repeat (10) tick();
    check("no_start_after_rst", 64'(start_cnt), 64'(s0));
    uart_en = 1'b1;
    send_ev(4'h9, 64'h0000_0000_0000_0001, 1'b1);
    wait_drain();
    check("post_rst_start_seen", 64'(start_cnt), 64'(s0 + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
